// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Pong match-score controller. Counts points from the ball/field
//            logic, drives both scoreboards' binary value and their shared
//            update strobe, paces refreshes on the converters' completion
//            flag and detects the win-by-margin end of a match.
// Ports    : clock      - system clock, rising edge
//            reset      - synchronous, active-high
//            point_p1/2 - 1-cycle pulse, player scored
//            new_game   - 1-cycle pulse, clear scores and restart
//            conv_done  - both scoreboards finished converting
//            score_p1/2 - binary scores to the scoreboards
//            update     - 1-cycle refresh strobe to both scoreboards
//            game_over  - match finished; winner valid (0=p1, 1=p2)
//            overrun    - sticky, a point was dropped
//            timeout    - sticky, conv_done never arrived in time
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter int SCORE_WIDTH  = 8,
  parameter int MAX_SCORE    = 99,
  parameter int WIN_SCORE    = 11,
  parameter int WIN_MARGIN   = 2,
  parameter int GUARD_CYCLES = 2,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   point_p1,
  input  logic                   point_p2,
  input  logic                   new_game,
  input  logic                   conv_done,
  output logic [SCORE_WIDTH-1:0] score_p1,
  output logic [SCORE_WIDTH-1:0] score_p2,
  output logic                   update,
  output logic                   game_over,
  output logic                   winner,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int CNT_W = $clog2(CONV_TIMEOUT + 1);

  localparam logic [SCORE_WIDTH-1:0] c_max_score  = SCORE_WIDTH'(MAX_SCORE);
  localparam logic [SCORE_WIDTH-1:0] c_win_score  = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [SCORE_WIDTH-1:0] c_win_margin = SCORE_WIDTH'(WIN_MARGIN);
  localparam logic [CNT_W-1:0]       c_guard      = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0]       c_wait_last  = CNT_W'(CONV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_PLAY      = 3'd0,
    ST_UPDATE    = 3'd1,
    ST_WAIT_CONV = 3'd2,
    ST_CHECK     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t                 state_q,    state_d;
  logic [SCORE_WIDTH-1:0] score_p1_q, score_p1_d;
  logic [SCORE_WIDTH-1:0] score_p2_q, score_p2_d;
  logic                   pend_p1_q,  pend_p1_d;
  logic                   pend_p2_q,  pend_p2_d;
  logic                   winner_q,   winner_d;
  logic                   overrun_q,  overrun_d;
  logic                   timeout_q,  timeout_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

  logic w_inc_p1;
  logic w_inc_p2;
  logic w_p1_wins;
  logic w_p2_wins;

  // The lead is only ever taken from the higher score, so the unsigned
  // subtraction can never wrap.
  assign w_p1_wins = (score_p1_q >= c_win_score) && (score_p1_q > score_p2_q) &&
                     ((score_p1_q - score_p2_q) >= c_win_margin);
  assign w_p2_wins = (score_p2_q >= c_win_score) && (score_p2_q > score_p1_q) &&
                     ((score_p2_q - score_p1_q) >= c_win_margin);

  // A pending point and a fresh point on the same PLAY cycle: the pending one
  // is applied now and the fresh one is re-pended, so nothing is lost.
  assign w_inc_p1 = point_p1 | pend_p1_q;
  assign w_inc_p2 = point_p2 | pend_p2_q;

  always_comb begin
    state_d    = state_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    pend_p1_d  = pend_p1_q;
    pend_p2_d  = pend_p2_q;
    winner_d   = winner_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;

    if (new_game) begin
      score_p1_d = '0;
      score_p2_d = '0;
      pend_p1_d  = 1'b0;
      pend_p2_d  = 1'b0;
      winner_d   = 1'b0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
      wait_cnt_d = '0;
      state_d    = ST_UPDATE;
    end else begin
      // While a refresh is in flight, points are parked in a one-deep
      // pending slot per player; a second one is dropped and flagged.
      if (state_q inside {ST_UPDATE, ST_WAIT_CONV, ST_CHECK}) begin
        if (point_p1) begin
          if (pend_p1_q) overrun_d = 1'b1;
          else           pend_p1_d = 1'b1;
        end
        if (point_p2) begin
          if (pend_p2_q) overrun_d = 1'b1;
          else           pend_p2_d = 1'b1;
        end
      end

      unique case (state_q)
        ST_PLAY: begin
          pend_p1_d = point_p1 & pend_p1_q;
          pend_p2_d = point_p2 & pend_p2_q;
          if (w_inc_p1 && (score_p1_q < c_max_score)) begin
            score_p1_d = score_p1_q + SCORE_WIDTH'(1);
          end
          if (w_inc_p2 && (score_p2_q < c_max_score)) begin
            score_p2_d = score_p2_q + SCORE_WIDTH'(1);
          end
          if (w_inc_p1 || w_inc_p2) begin
            state_d = ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT_CONV;
        end
        ST_WAIT_CONV: begin
          // The converters' done flag may still be high from the previous
          // refresh during the guard window, so it is not trusted there.
          if ((wait_cnt_q >= c_guard) && conv_done) begin
            state_d = ST_CHECK;
          end else if (wait_cnt_q == c_wait_last) begin
            timeout_d = 1'b1;
            state_d   = ST_CHECK;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_p1_wins) begin
            winner_d = 1'b0;
            state_d  = ST_GAME_OVER;
          end else if (w_p2_wins) begin
            winner_d = 1'b1;
            state_d  = ST_GAME_OVER;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_GAME_OVER: begin
          state_d = ST_GAME_OVER;
        end
        default: begin
          state_d = ST_UPDATE;
        end
      endcase
    end
  end

  // Reset parks the FSM in UPDATE so the scoreboards are refreshed to 00 on
  // the first cycle after reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_UPDATE;
      score_p1_q <= '0;
      score_p2_q <= '0;
      pend_p1_q  <= 1'b0;
      pend_p2_q  <= 1'b0;
      winner_q   <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      pend_p1_q  <= pend_p1_d;
      pend_p2_q  <= pend_p2_d;
      winner_q   <= winner_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The strobe is masked while reset is held, since the state register
  // already sits in UPDATE during reset.
  assign update    = (state_q == ST_UPDATE) & ~reset;
  assign game_over = (state_q == ST_GAME_OVER);
  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign winner    = winner_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire
